// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// The optional illegal-opcode trap is enabled by the CTRL_ILLEGAL_TRAP_EN macro.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExtFetch,
        StExtExec,
        StHalt
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_MUL  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_INV1 = 4'h7;
    localparam logic [3:0] OP_INV2 = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_MVI  = 4'hC;
    localparam logic [3:0] OP_LDA  = 4'hD;
    localparam logic [3:0] OP_LDX  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_ADDR  = 2'b00;
    localparam logic [1:0] ALU_ARITH = 2'b01;
    localparam logic [1:0] ALU_LOGIC = 2'b10;

    // Number of extension words following the opcode word.
    function automatic logic [1:0] ext_words(input logic [3:0] op);
        logic [1:0] n;
        case (op)
            OP_MVI, OP_LDA: n = 2'd1;
            OP_LDX:         n = 2'd2;
            default:        n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: datapath strobes, extension word count and legality.
// Opcode bits above [3:0] being nonzero, or LDX with MAX_EXT < 2, marks the opcode illegal.
import ctrl_seq_pkg::*;

module ctrl_decode #(
    parameter int unsigned OPC_W      = 4,
    parameter int unsigned ALU_MODE_W = 2,
    parameter int unsigned MAX_EXT    = 2
) (
    input  logic [OPC_W-1:0]      i_opcode,
    output logic [ALU_MODE_W-1:0] o_alu_mode,
    output logic                  o_op1_load,
    output logic                  o_op2_load,
    output logic                  o_reg_load,
    output logic [1:0]            o_ext_words,
    output logic                  o_halt,
    output logic                  o_illegal
);

    logic [3:0] w_op;
    logic       w_hi_bad;
    logic       w_ldx_bad;

    assign w_op = i_opcode[3:0];

    if (OPC_W > 4) begin : g_hi_bits
        assign w_hi_bad = |i_opcode[OPC_W-1:4];
    end else begin : g_no_hi_bits
        assign w_hi_bad = 1'b0;
    end

    always_comb begin
        o_alu_mode  = '0;
        o_op1_load  = 1'b0;
        o_op2_load  = 1'b0;
        o_reg_load  = 1'b0;
        o_ext_words = ext_words(w_op);
        o_halt      = 1'b0;
        w_ldx_bad   = 1'b0;
        case (w_op)
            OP_ADD, OP_MUL, OP_SUB, OP_DIV: begin
                o_alu_mode = ALU_MODE_W'(ALU_ARITH);
                o_op1_load = 1'b1;
                o_op2_load = 1'b1;
                o_reg_load = 1'b1;
            end
            OP_AND, OP_OR, OP_NOR, OP_XOR, OP_XNOR: begin
                o_alu_mode = ALU_MODE_W'(ALU_LOGIC);
                o_op1_load = 1'b1;
                o_op2_load = 1'b1;
                o_reg_load = 1'b1;
            end
            OP_INV1: begin
                o_alu_mode = ALU_MODE_W'(ALU_LOGIC);
                o_op1_load = 1'b1;
                o_reg_load = 1'b1;
            end
            OP_INV2: begin
                o_alu_mode = ALU_MODE_W'(ALU_LOGIC);
                o_op2_load = 1'b1;
                o_reg_load = 1'b1;
            end
            OP_MOV: begin
                o_alu_mode = ALU_MODE_W'(ALU_ADDR);
                o_op2_load = 1'b1;
                o_reg_load = 1'b1;
            end
            OP_MVI:  o_op1_load = 1'b1;
            OP_LDX:  w_ldx_bad  = (MAX_EXT < 2);
            OP_HLT:  o_halt     = 1'b1;
            default: ;
        endcase

        o_illegal = w_hi_bad | w_ldx_bad;
        if (o_illegal) begin
            o_alu_mode  = '0;
            o_op1_load  = 1'b0;
            o_op2_load  = 1'b0;
            o_reg_load  = 1'b0;
            o_ext_words = 2'd0;
            o_halt      = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_seq_fsm.sv
// Multi-cycle control sequencer: fetch/decode/extension-word FSM driving datapath strobes.
// CTRL_ILLEGAL_TRAP_EN adds a sticky o_trap output and halts on illegal opcodes.
import ctrl_seq_pkg::*;

module ctrl_seq_fsm #(
    parameter int unsigned OPC_W      = 4,
    parameter int unsigned ALU_MODE_W = 2,
    parameter int unsigned MAX_EXT    = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic [OPC_W-1:0]               i_opcode,
    input  logic                           i_imem_valid,
    output logic                           o_imem_req,
    output logic [ALU_MODE_W-1:0]          o_alu_mode,
    output logic                           o_ins_load,
    output logic                           o_op1_load,
    output logic                           o_op2_load,
    output logic                           o_pc_load,
    output logic                           o_pc_inc,
    output logic                           o_reg_load,
    output logic [$clog2(MAX_EXT+1)-1:0]   o_ext_idx,
    output logic                           o_busy,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                           o_trap,
`endif
    output logic                           o_halted
);

    localparam int unsigned EXT_W = $clog2(MAX_EXT + 1);

    state_e                  r_state;
    logic [3:0]              r_op;
    logic [EXT_W-1:0]        r_ext_cnt;

    logic [ALU_MODE_W-1:0]   w_alu_mode;
    logic                    w_op1_load;
    logic                    w_op2_load;
    logic                    w_reg_load;
    logic [1:0]              w_ext_words;
    logic                    w_halt;
    logic                    w_illegal;
    logic [EXT_W-1:0]        w_ext_idx;
    logic                    w_dec_pc_inc;

    ctrl_decode #(
        .OPC_W      (OPC_W),
        .ALU_MODE_W (ALU_MODE_W),
        .MAX_EXT    (MAX_EXT)
    ) u_decode (
        .i_opcode    (i_opcode),
        .o_alu_mode  (w_alu_mode),
        .o_op1_load  (w_op1_load),
        .o_op2_load  (w_op2_load),
        .o_reg_load  (w_reg_load),
        .o_ext_words (w_ext_words),
        .o_halt      (w_halt),
        .o_illegal   (w_illegal)
    );

    // Index of the extension word in flight: words already consumed plus one.
    assign w_ext_idx = EXT_W'(32'(ext_words(r_op)) - 32'(r_ext_cnt) + 32'd1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_trap;
    assign o_trap       = r_trap;
    assign w_dec_pc_inc = ~w_halt & ~w_illegal;
`else
    assign w_dec_pc_inc = ~w_halt;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_op      <= 4'h0;
            r_ext_cnt <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_trap    <= 1'b0;
`endif
        end else if (i_en) begin
            case (r_state)
                StIdle: r_state <= StFetch;
                StFetch: begin
                    if (i_imem_valid) begin
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    r_op <= i_opcode[3:0];
                    if (w_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        r_trap  <= 1'b1;
                        r_state <= StHalt;
`else
                        r_state <= StFetch;
`endif
                    end else if (w_halt) begin
                        r_state <= StHalt;
                    end else if (w_ext_words != 2'd0) begin
                        r_ext_cnt <= EXT_W'(w_ext_words);
                        r_state   <= StExtFetch;
                    end else begin
                        r_state <= StFetch;
                    end
                end
                StExtFetch: begin
                    if (i_imem_valid) begin
                        r_state <= StExtExec;
                    end
                end
                StExtExec: begin
                    if (r_ext_cnt == EXT_W'(1)) begin
                        r_ext_cnt <= '0;
                        r_state   <= StFetch;
                    end else begin
                        r_ext_cnt <= r_ext_cnt - EXT_W'(1);
                        r_state   <= StExtFetch;
                    end
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_alu_mode = '0;
        o_ins_load = 1'b0;
        o_op1_load = 1'b0;
        o_op2_load = 1'b0;
        o_pc_load  = 1'b0;
        o_pc_inc   = 1'b0;
        o_reg_load = 1'b0;
        o_ext_idx  = '0;
        o_busy     = (r_state != StIdle) && (r_state != StHalt);
        o_halted   = (r_state == StHalt);
        if (i_en) begin
            case (r_state)
                StFetch: begin
                    o_imem_req = 1'b1;
                    o_pc_load  = 1'b1;
                    o_ins_load = i_imem_valid;
                end
                StDecode: begin
                    o_alu_mode = w_alu_mode;
                    o_op1_load = w_op1_load;
                    o_op2_load = w_op2_load;
                    o_reg_load = w_reg_load;
                    o_pc_inc   = w_dec_pc_inc;
                end
                StExtFetch: begin
                    o_imem_req = 1'b1;
                    o_pc_load  = 1'b1;
                    o_ext_idx  = w_ext_idx;
                end
                StExtExec: begin
                    o_alu_mode = ALU_MODE_W'(ALU_ADDR);
                    o_pc_inc   = 1'b1;
                    o_reg_load = (r_ext_cnt == EXT_W'(1));
                    o_ext_idx  = w_ext_idx;
                end
                default: ;
            endcase
        end
    end

endmodule
